syncfifo_prog: RTL

Parametrised single-clock FIFO that succeeds the fixed 8×511 `syncfifo`. It adds full power-of-two depth, programmable almost-full and almost-empty thresholds, and a selectable first-word-fall-through (FWFT) read mode. It also adds sticky overflow/underflow error flags and a read-valid strobe. It sits between same-clock producer and consumer stages in the datapath and owns its storage as an internal register array (no dp_ram instance).

---
 rtl/syncfifo_prog.sv | 102 ++++++++++
 1 files changed

// File: rtl/syncfifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// selectable registered or fall-through read, and sticky overflow/underflow flags.
module syncfifo_prog #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 9,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clock,
  input  logic                  fifo_rst,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_counter,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  write_allow;
  logic                  read_allow;

  // Flags decode the registered count so they always agree with fifo_counter.
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);
  assign fifo_counter = count;

  assign write_allow = write_enable & ~full;
  assign read_allow  = read_enable & ~empty;

  always_ff @(posedge clock) begin
    if (fifo_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_allow) wr_ptr <= wr_ptr + 1'b1;
      if (read_allow)  rd_ptr <= rd_ptr + 1'b1;
      case ({write_allow, read_allow})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (write_allow && !fifo_rst) mem[wr_ptr] <= write_data;
  end

  // A set in the same cycle as clear_err wins over the clear.
  always_ff @(posedge clock) begin
    if (fifo_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (write_enable & full)  | (overflow  & ~clear_err);
      underflow <= (read_enable  & empty) | (underflow & ~clear_err);
    end
  end

  if (FWFT == 1'b0) begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clock) begin
      if (fifo_rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= read_allow;
        if (read_allow) rd_data_q <= mem[rd_ptr];
      end
    end

    assign read_data  = rd_data_q;
    assign read_valid = rd_valid_q;
  end else begin : g_fwft
    // Head word is presented directly; the pop moves rd_ptr to the next word.
    assign read_data  = mem[rd_ptr];
    assign read_valid = ~empty;
  end

endmodule
